// File: rtl/hpdcache_axi_read_responder.sv
// AXI4 read responder: serves AR bursts from a word-addressed synchronous SRAM, one burst at a time.
// Optional exclusive-access (EXOKAY) response enabled by defining HPDCACHE_AXI_RD_RESP_EXCL_EN.
package hpdcache_axi_rd_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;
endpackage

module hpdcache_axi_read_responder #(
  parameter type                   ar_chan_t    = hpdcache_axi_rd_pkg::ar_chan_t,
  parameter type                   r_chan_t     = hpdcache_axi_rd_pkg::r_chan_t,
  parameter int unsigned           AddrWidth    = 64,
  parameter int unsigned           DataWidth    = 64,
  parameter logic [AddrWidth-1:0]  MemBaseAddr  = '0,
  parameter int unsigned           MemSizeBytes = 65536,
  parameter int unsigned           MemAddrWidth = $clog2(MemSizeBytes / (DataWidth / 8))
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    axi_ar_valid_i,
  input  ar_chan_t                axi_ar_i,
  output logic                    axi_ar_ready_o,
  output logic                    axi_r_valid_o,
  output r_chan_t                 axi_r_o,
  input  logic                    axi_r_ready_i,
  output logic                    mem_rd_en_o,
  output logic [MemAddrWidth-1:0] mem_rd_addr_o,
  input  logic [DataWidth-1:0]    mem_rd_data_i
);
  localparam int unsigned ByteOffs = $clog2(DataWidth / 8);
  localparam int unsigned IdWidth  = $bits(axi_r_o.id);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q, cnt_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
`ifdef HPDCACHE_AXI_RD_RESP_EXCL_EN
  logic                 lock_q;
`endif

  logic                 ar_hs, issue, beat_err, r_pop, credit_ok;
  logic [AddrWidth-1:0] off;
  r_chan_t              beat, meta_q, push_entry;
  logic                 err_q, in_flight_q;
  r_chan_t              fifo_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           fill_q;

  assign ar_hs          = axi_ar_valid_i && axi_ar_ready_o;
  assign axi_ar_ready_o = (state_q == IDLE);

  // Offset wraps negative addresses to huge values, so one compare covers both window edges.
  assign off           = addr_q - MemBaseAddr;
  assign beat_err      = (burst_q != 2'b01) || !(off < AddrWidth'(MemSizeBytes)) ||
                         (size_q > 3'(ByteOffs));
  assign mem_rd_addr_o = off[ByteOffs +: MemAddrWidth];
  assign mem_rd_en_o   = issue && !beat_err;

  // Credit counts the beat leaving this cycle so a full pipe still sustains one beat per cycle.
  assign r_pop     = axi_r_valid_o && axi_r_ready_i;
  assign credit_ok = ({1'b0, fill_q} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, r_pop});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (state_q == IDLE) begin
      if (axi_ar_valid_i) state_d = BURST;
    end else if (credit_ok) begin
      issue = 1'b1;
      if (cnt_q == len_q) state_d = IDLE;
    end
  end

  always_comb begin
    beat      = '0;
    beat.id   = id_q;
    beat.last = (cnt_q == len_q);
    if (beat_err) beat.resp[1:0] = 2'b10;
`ifdef HPDCACHE_AXI_RD_RESP_EXCL_EN
    else if (lock_q) beat.resp[1:0] = 2'b01;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
`ifdef HPDCACHE_AXI_RD_RESP_EXCL_EN
      lock_q      <= 1'b0;
`endif
      in_flight_q <= 1'b0;
      err_q       <= 1'b0;
      meta_q      <= '0;
    end else begin
      if (ar_hs) begin
        id_q    <= axi_ar_i.id;
        addr_q  <= axi_ar_i.addr;
        len_q   <= axi_ar_i.len;
        size_q  <= axi_ar_i.size;
        burst_q <= axi_ar_i.burst;
        cnt_q   <= '0;
`ifdef HPDCACHE_AXI_RD_RESP_EXCL_EN
        lock_q  <= axi_ar_i.lock;
`endif
      end else if (issue) begin
        addr_q <= addr_q + (AddrWidth'(1) << size_q);
        cnt_q  <= cnt_q + 8'd1;
      end
      in_flight_q <= issue;
      if (issue) begin
        meta_q <= beat;
        err_q  <= beat_err;
      end
    end
  end

  // SRAM data joins its beat metadata one cycle after the read was issued.
  always_comb begin
    push_entry      = meta_q;
    push_entry.data = err_q ? '0 : mem_rd_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= '0;
    end else begin
      if (in_flight_q) wr_ptr_q <= ~wr_ptr_q;
      if (r_pop)       rd_ptr_q <= ~rd_ptr_q;
      fill_q <= fill_q + {1'b0, in_flight_q} - {1'b0, r_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_flight_q) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign axi_r_valid_o = (fill_q != 2'd0);
  assign axi_r_o       = axi_r_valid_o ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_hpdcache_axi_read_responder.sv
// Scoreboard bench for hpdcache_axi_read_responder: directed AR bursts, R beats checked by a monitor.
module tb_hpdcache_axi_read_responder;
  import hpdcache_axi_rd_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int unsigned SIZE = 65536;
`ifdef HPDCACHE_AXI_RD_RESP_EXCL_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ar_valid = 1'b0, ar_ready, r_valid, r_ready = 1'b1, mem_rd_en;
  ar_chan_t    ar = '0;
  r_chan_t     r;
  logic [12:0] mem_rd_addr;
  logic [63:0] mem_rd_data = '0;

  always #5 clk = ~clk;

  hpdcache_axi_read_responder #(.MemBaseAddr(BASE), .MemSizeBytes(SIZE)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_ar_valid_i(ar_valid), .axi_ar_i(ar), .axi_ar_ready_o(ar_ready),
    .axi_r_valid_o(r_valid), .axi_r_o(r), .axi_r_ready_i(r_ready),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data)
  );

  int      vectors = 0, miscompares = 0;
  int      cyc = 0, mem_reads = 0, rr_mode = 0, hs_cyc = 0;
  r_chan_t exp_q[$];
  int      pop_cyc[$];

  function automatic logic [63:0] pat(input logic [12:0] w);
    return {16'hC0DE, 3'b000, w, ~{19'b0, w}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);
  always @(posedge clk) if (mem_rd_en) mem_reads <= mem_reads + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: r_ready = 1'b1;
        1: r_ready = ~r_ready;
        default: r_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expectation per R handshake, and checks payload holds across stalls.
  initial begin
    r_chan_t prev;
    logic    stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) chk("r_hold", {r_valid, r}, {1'b1, prev});
        if (r_valid && r_ready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL r_unexpected got=%0h exp=none", r);
          end else chk("r_beat", r, exp_q.pop_front());
        end
        stall = r_valid && !r_ready;
        prev  = r;
      end
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic lock,
                         output int nrd);
    logic [63:0] a, off;
    logic        err;
    r_chan_t     e;
    int          k;
    a = addr;
    nrd = 0;
    for (int i = 0; i <= int'(len); i++) begin
      off = a - BASE;
      err = (burst != 2'b01) || (off >= 64'(SIZE)) || (size > 3'd3);
      e = '0;
      e.id   = id;
      e.last = (i == int'(len));
      e.resp = err ? 4'b0010 : ((EXCL && lock) ? 4'b0001 : 4'b0000);
      e.data = err ? 64'd0 : pat(off[15:3]);
      if (!err) nrd++;
      exp_q.push_back(e);
      a = a + (64'd1 << size);
    end
    @(negedge clk);
    ar_valid = 1'b1;
    ar.id = id; ar.addr = addr; ar.len = len; ar.size = size; ar.burst = burst; ar.lock = lock;
    k = 0;
    while (!ar_ready && k < 600) begin @(negedge clk); k++; end
    if (!ar_ready) begin
      vectors++; miscompares++;
      $display("FAIL ar_timeout got=0 exp=1");
    end
    hs_cyc = cyc;
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n, n2, m0;
    repeat (3) @(negedge clk);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_r_payload", r, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single beat, latency T+3
    m0 = mem_reads; pop_cyc.delete();
    send_ar(4'd3, BASE, 8'd0, 3'd3, 2'b01, 1'b0, n);
    drain();
    chk("single_latency", (pop_cyc.size() > 0) ? pop_cyc[0] - hs_cyc : -1, 3);
    chk("single_reads", mem_reads - m0, n);

    // 8 back-to-back beats
    m0 = mem_reads; pop_cyc.delete();
    send_ar(4'd1, BASE + 64'h40, 8'd7, 3'd3, 2'b01, 1'b0, n);
    drain();
    chk("b2b_span", (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1, 7);
    chk("b2b_reads", mem_reads - m0, n);

    // same burst with r_ready toggling
    rr_mode = 1;
    m0 = mem_reads;
    send_ar(4'd2, BASE + 64'h40, 8'd7, 3'd3, 2'b01, 1'b0, n);
    drain();
    chk("toggle_reads", mem_reads - m0, n);

    // two ARs queued behind each other while draining
    m0 = mem_reads;
    send_ar(4'd7, BASE + 64'h80, 8'd3, 3'd3, 2'b01, 1'b0, n);
    send_ar(4'd8, BASE + 64'h100, 8'd2, 3'd3, 2'b01, 1'b0, n2);
    drain();
    chk("overlap_reads", mem_reads - m0, n + n2);
    rr_mode = 0;

    // crossing the top of the window
    m0 = mem_reads;
    send_ar(4'd4, BASE + 64'(SIZE) - 64'd16, 8'd3, 3'd3, 2'b01, 1'b0, n);
    drain();
    chk("edge_reads", mem_reads - m0, 2);

    // below the window, WRAP burst, oversize beat
    m0 = mem_reads;
    send_ar(4'd9, BASE - 64'd8, 8'd1, 3'd3, 2'b01, 1'b0, n);
    send_ar(4'd5, BASE, 8'd1, 3'd3, 2'b10, 1'b0, n);
    send_ar(4'd6, BASE, 8'd0, 3'd4, 2'b01, 1'b0, n);
    drain();
    chk("err_reads", mem_reads - m0, 1);

    // exclusive, narrow beats, max length
    send_ar(4'd10, BASE + 64'h20, 8'd1, 3'd3, 2'b01, 1'b1, n);
    send_ar(4'd11, BASE + 64'h4, 8'd3, 3'd2, 2'b01, 1'b0, n);
    drain();
    m0 = mem_reads;
    send_ar(4'd12, BASE, 8'd255, 3'd3, 2'b01, 1'b0, n);
    drain();
    chk("len255_reads", mem_reads - m0, 256);

    // reset in the middle of a 16-beat burst
    rr_mode = 2;
    send_ar(4'd13, BASE + 64'h100, 8'd15, 3'd3, 2'b01, 1'b0, n);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ar_ready", ar_ready, 1);
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_mem_rd_en", mem_rd_en, 0);
    chk("midrst_r_payload", r, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_mode = 0;
    m0 = mem_reads;
    send_ar(4'd14, BASE + 64'h200, 8'd1, 3'd3, 2'b01, 1'b0, n);
    drain();
    chk("postrst_reads", mem_reads - m0, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
